// File: rtl/vga_csr_responder_pkg.sv
// rtl/vga_csr_responder_pkg.sv - shared constants for the VGA CSR responder
//
// Purpose : CPU access FSM encoding, display read latency and the SRAM
//           control values driven while no CPU write owns the slot.
// Ports   : none (package).
package vga_csr_responder_pkg;

   // CPU access FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;

   // Display read latency: strobe in cycle N, data valid in cycle N+2
   localparam int CSR_RD_LATENCY = 2;

   // SRAM control levels for idle and read slots
   localparam logic       SRAM_WE_N_IDLE = 1'b1;
   localparam logic [1:0] SRAM_BW_N_IDLE = 2'b11;
   localparam logic       SRAM_OE_IDLE   = 1'b0;

endpackage

// File: rtl/vga_csr_responder.sv
// rtl/vga_csr_responder.sv - VGA CSR read responder sharing video SRAM with the CPU
//
// Purpose : Serves display word reads from 16-bit SRAM with a fixed
//           two-cycle latency and slips CPU reads/writes into slots the
//           display leaves unused.
// Ports   : clk, rst            - video clock, synchronous active-high reset
//           csr_adr_i/stb_i     - display read address and strobe
//           csr_dat_o           - display read data (valid 2 cycles later)
//           cpu_adr_i/dat_i/sel_i/we_i/stb_i - CPU request, held until ack
//           cpu_dat_o, cpu_ack_o - CPU read data and one-cycle ack
//           sram_*              - registered SRAM pad controls and data
module vga_csr_responder
   import vga_csr_responder_pkg::*;
#(
   parameter int ADR_W = 17,
   parameter int DAT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADR_W-1:0] csr_adr_i,
   input  logic             csr_stb_i,
   output logic [DAT_W-1:0] csr_dat_o,
   input  logic [ADR_W-1:0] cpu_adr_i,
   input  logic [DAT_W-1:0] cpu_dat_i,
   input  logic [1:0]       cpu_sel_i,
   input  logic             cpu_we_i,
   input  logic             cpu_stb_i,
   output logic [DAT_W-1:0] cpu_dat_o,
   output logic             cpu_ack_o,
   output logic [ADR_W-1:0] sram_adr_o,
   output logic [DAT_W-1:0] sram_dat_o,
   output logic             sram_dat_oe_o,
   input  logic [DAT_W-1:0] sram_dat_i,
   output logic             sram_we_n_o,
   output logic [1:0]       sram_bw_n_o
);

   // One bit per display pipeline stage between address issue and capture
   localparam int VLD_W = CSR_RD_LATENCY - 1;

   logic [1:0]       state;
   logic             cpu_wr;
   logic [VLD_W-1:0] disp_vld;
   logic             cpu_grant;

   // The display always wins; the CPU only gets a slot the display leaves
   // empty, and never while a previous access is still being acked.
   assign cpu_grant = !csr_stb_i && (state == ST_IDLE) && cpu_stb_i && !cpu_ack_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         cpu_wr        <= 1'b0;
         disp_vld      <= '0;
         csr_dat_o     <= '0;
         cpu_dat_o     <= '0;
         cpu_ack_o     <= 1'b0;
         sram_adr_o    <= '0;
         sram_dat_o    <= '0;
         sram_dat_oe_o <= SRAM_OE_IDLE;
         sram_we_n_o   <= SRAM_WE_N_IDLE;
         sram_bw_n_o   <= SRAM_BW_N_IDLE;
      end else begin
         // Controls fall back to idle every cycle; only a CPU write grant
         // overrides them, so the pads are driven for exactly one cycle.
         sram_dat_oe_o <= SRAM_OE_IDLE;
         sram_we_n_o   <= SRAM_WE_N_IDLE;
         sram_bw_n_o   <= SRAM_BW_N_IDLE;

         // Tracking display reads separately keeps CPU read data out of
         // csr_dat_o even when both share the same SRAM data bus.
         disp_vld <= (disp_vld << 1) | VLD_W'(csr_stb_i);
         if (disp_vld[VLD_W-1]) begin
            csr_dat_o <= sram_dat_i;
         end

         if (csr_stb_i) begin
            sram_adr_o <= csr_adr_i;
         end else if (cpu_grant) begin
            sram_adr_o <= cpu_adr_i;
            if (cpu_we_i) begin
               sram_dat_o    <= cpu_dat_i;
               sram_dat_oe_o <= 1'b1;
               sram_we_n_o   <= 1'b0;
               sram_bw_n_o   <= ~cpu_sel_i;
            end
         end

         case (state)
            ST_IDLE: begin
               if (cpu_grant) begin
                  cpu_wr <= cpu_we_i;
                  state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // SRAM still holds the CPU address this cycle even if the
               // display is registering a new one for the next slot.
               if (!cpu_wr) begin
                  cpu_dat_o <= sram_dat_i;
               end
               cpu_ack_o <= 1'b1;
               state     <= ST_ACK;
            end
            ST_ACK: begin
               cpu_ack_o <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               cpu_ack_o <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_csr_responder.sv
// tb/tb_vga_csr_responder.sv - directed self-checking bench for vga_csr_responder
module tb_vga_csr_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] csr_adr_i;
   logic        csr_stb_i;
   logic [15:0] csr_dat_o;
   logic [16:0] cpu_adr_i;
   logic [15:0] cpu_dat_i;
   logic [1:0]  cpu_sel_i;
   logic        cpu_we_i;
   logic        cpu_stb_i;
   logic [15:0] cpu_dat_o;
   logic        cpu_ack_o;
   logic [16:0] sram_adr_o;
   logic [15:0] sram_dat_o;
   logic        sram_dat_oe_o;
   logic [15:0] sram_dat_i;
   logic        sram_we_n_o;
   logic [1:0]  sram_bw_n_o;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:131071];

   vga_csr_responder dut (
      .clk           (clk),
      .rst           (rst),
      .csr_adr_i     (csr_adr_i),
      .csr_stb_i     (csr_stb_i),
      .csr_dat_o     (csr_dat_o),
      .cpu_adr_i     (cpu_adr_i),
      .cpu_dat_i     (cpu_dat_i),
      .cpu_sel_i     (cpu_sel_i),
      .cpu_we_i      (cpu_we_i),
      .cpu_stb_i     (cpu_stb_i),
      .cpu_dat_o     (cpu_dat_o),
      .cpu_ack_o     (cpu_ack_o),
      .sram_adr_o    (sram_adr_o),
      .sram_dat_o    (sram_dat_o),
      .sram_dat_oe_o (sram_dat_oe_o),
      .sram_dat_i    (sram_dat_i),
      .sram_we_n_o   (sram_we_n_o),
      .sram_bw_n_o   (sram_bw_n_o)
   );

   always #20 clk = ~clk;

   // Asynchronous-read, synchronous-write SRAM model
   assign sram_dat_i = mem[sram_adr_o];

   always @(posedge clk) begin
      if (!sram_we_n_o) begin
         if (!sram_bw_n_o[1]) mem[sram_adr_o][15:8] <= sram_dat_o[15:8];
         if (!sram_bw_n_o[0]) mem[sram_adr_o][7:0]  <= sram_dat_o[7:0];
      end
   end

   function automatic logic [15:0] pre(input int a);
      return 16'(a) ^ 16'hA5A5;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_csr_dat"}, 32'(csr_dat_o), 32'h0);
      check({tag, "_cpu_dat"}, 32'(cpu_dat_o), 32'h0);
      check({tag, "_ack"},     32'(cpu_ack_o), 32'h0);
      check({tag, "_adr"},     32'(sram_adr_o), 32'h0);
      check({tag, "_sdat"},    32'(sram_dat_o), 32'h0);
      check({tag, "_oe"},      32'(sram_dat_oe_o), 32'h0);
      check({tag, "_we_n"},    32'(sram_we_n_o), 32'h1);
      check({tag, "_bw_n"},    32'(sram_bw_n_o), 32'h3);
      check({tag, "_state"},   32'(dut.state), 32'h0);
   endtask

   initial begin
      int acks;
      int hits;

      for (int a = 0; a < 131072; a++) mem[a] <= pre(a);

      rst = 1'b1;
      csr_adr_i = '0; csr_stb_i = 1'b0;
      cpu_adr_i = '0; cpu_dat_i = '0; cpu_sel_i = '0; cpu_we_i = 1'b0; cpu_stb_i = 1'b0;
      tick(); tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Display burst 0x100..0x10F, one word per cycle, data two cycles later
      for (int c = 0; c < 18; c++) begin
         csr_stb_i = (c < 16);
         csr_adr_i = 17'(32'h100 + c);
         tick();
         check("burst_we_n", 32'(sram_we_n_o), 32'h1);
         if (c >= 1 && c <= 16) check("burst_dat", 32'(csr_dat_o), 32'(pre(32'h100 + c - 1)));
      end
      csr_stb_i = 1'b0;

      // CPU write, upper byte only
      cpu_stb_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 17'h00200;
      cpu_dat_i = 16'h1234; cpu_sel_i = 2'b10;
      tick();
      check("wr_bw_n", 32'(sram_bw_n_o), 32'h1);
      check("wr_we_n", 32'(sram_we_n_o), 32'h0);
      check("wr_oe",   32'(sram_dat_oe_o), 32'h1);
      check("wr_adr",  32'(sram_adr_o), 32'h200);
      check("wr_ack_early", 32'(cpu_ack_o), 32'h0);
      tick();
      check("wr_ack", 32'(cpu_ack_o), 32'h1);
      check("wr_we_n_after", 32'(sram_we_n_o), 32'h1);
      cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
      tick();
      check("wr_ack_single", 32'(cpu_ack_o), 32'h0);
      check("wr_mem", 32'(mem[17'h200]), 32'h12A5);

      // CPU read blocked by 40 cycles of display strobes
      cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 17'h00300;
      acks = 0; hits = 0;
      for (int i = 0; i < 40; i++) begin
         csr_stb_i = 1'b1;
         csr_adr_i = 17'(32'h500 + i);
         tick();
         if (cpu_ack_o) acks++;
         if (sram_adr_o == 17'h00300 || !sram_we_n_o) hits++;
      end
      check("blk_no_ack", 32'(acks), 32'h0);
      check("blk_no_cpu_cycle", 32'(hits), 32'h0);
      csr_stb_i = 1'b0;
      tick();
      check("blk_grant_adr", 32'(sram_adr_o), 32'h300);
      check("blk_ack_early", 32'(cpu_ack_o), 32'h0);
      tick();
      check("blk_ack", 32'(cpu_ack_o), 32'h1);
      check("blk_cpu_dat", 32'(cpu_dat_o), 32'hA6A5);
      check("blk_csr_dat", 32'(csr_dat_o), 32'hA082);
      cpu_stb_i = 1'b0;
      tick();

      // Interleave: CPU read at N, display strobe at N+1
      cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 17'h00310;
      tick();
      csr_stb_i = 1'b1; csr_adr_i = 17'h00400;
      tick();
      check("il_ack", 32'(cpu_ack_o), 32'h1);
      check("il_cpu_dat", 32'(cpu_dat_o), 32'hA6B5);
      check("il_csr_hold", 32'(csr_dat_o), 32'hA082);
      csr_stb_i = 1'b0; cpu_stb_i = 1'b0;
      tick();
      check("il_csr_dat", 32'(csr_dat_o), 32'hA1A5);

      // Reset while the CPU access is in ISSUE
      cpu_stb_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 17'h00600;
      cpu_dat_i = 16'hBEEF; cpu_sel_i = 2'b11;
      tick();
      check("rst_in_issue", 32'(dut.state), 32'h1);
      rst = 1'b1;
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cpu_ack_o) acks++;
      end
      check("midrst_no_ack", 32'(acks), 32'h0);

      // Turnaround: write then display read of the same word
      cpu_stb_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 17'h00700;
      cpu_dat_i = 16'h5A5A; cpu_sel_i = 2'b11;
      tick();
      check("ta_oe_write", 32'(sram_dat_oe_o), 32'h1);
      csr_stb_i = 1'b1; csr_adr_i = 17'h00700;
      tick();
      check("ta_oe_read", 32'(sram_dat_oe_o), 32'h0);
      check("ta_we_n_read", 32'(sram_we_n_o), 32'h1);
      check("ta_ack", 32'(cpu_ack_o), 32'h1);
      csr_stb_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
      tick();
      check("ta_csr_dat", 32'(csr_dat_o), 32'h5A5A);

      // Write with no byte lanes: acked, memory untouched
      cpu_stb_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 17'h00800;
      cpu_dat_i = 16'h0000; cpu_sel_i = 2'b00;
      tick();
      check("sel0_bw_n", 32'(sram_bw_n_o), 32'h3);
      tick();
      check("sel0_ack", 32'(cpu_ack_o), 32'h1);
      cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
      tick();
      check("sel0_mem", 32'(mem[17'h800]), 32'hADA5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_csr_responder.md
Name: vga_csr_responder

Overview:
- Responder end of the VGA CSR read interface. Serves the display pipeline's word reads (csr_adr/csr_stb/csr_dat) from external 16-bit video SRAM with a fixed 2-cycle latency.
- Multiplexes CPU-side read and write accesses into SRAM cycles the display does not use.
- Sits between the lcd controller, the CPU/Wishbone VGA memory window, and the SRAM pads.

Parameters:
- ADR_W, 17, word address width (address bits [ADR_W:1]).
- DAT_W, 16, data width; fixed at 16 with two byte lanes.

Ports:
- clk  in  1  25 MHz video clock
- rst  in  1  synchronous active-high reset
- csr_adr_i  in  17  display word address [17:1]
- csr_stb_i  in  1  display read strobe; one read per high cycle
- csr_dat_o  out  16  display read data, valid 2 cycles after strobe
- cpu_adr_i  in  17  CPU word address [17:1]
- cpu_dat_i  in  16  CPU write data
- cpu_sel_i  in  2  CPU byte lane enables (bit1 = [15:8])
- cpu_we_i  in  1  CPU write enable
- cpu_stb_i  in  1  CPU request; held until ack
- cpu_dat_o  out  16  CPU read data, valid with ack
- cpu_ack_o  out  1  one-cycle acknowledge
- sram_adr_o  out  17  SRAM word address (registered)
- sram_dat_o  out  16  SRAM write data (registered)
- sram_dat_oe_o  out  1  drive enable for the SRAM data pads
- sram_dat_i  in  16  SRAM read data (asynchronous, valid within cycle)
- sram_we_n_o  out  1  active-low write strobe
- sram_bw_n_o  out  2  active-low byte write enables

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - csr_dat_o=0, cpu_dat_o=0, cpu_ack_o=0, sram_adr_o=0, sram_dat_o=0.
  - sram_dat_oe_o=0, sram_we_n_o=1, sram_bw_n_o=2'b11.
  - FSM=IDLE.
- Slot ownership, decided every cycle N:
  - Display owns the slot when csr_stb_i=1. It has absolute priority and is never stalled or delayed.
  - CPU owns the slot only when csr_stb_i=0, FSM=IDLE, cpu_stb_i=1 and cpu_ack_o=0.
  - Otherwise the slot is idle: sram_we_n_o=1, sram_dat_oe_o=0, sram_adr_o holds.
- Display read pipeline:
  - End of N: sram_adr_o <= csr_adr_i, we_n=1, oe=0.
  - End of N+1: csr_dat_o <= sram_dat_i.
  - csr_dat_o is valid throughout N+2 and holds until the next display capture.
  - Back-to-back strobes give one word per cycle.
  - A display capture stage is tracked by a 1-bit valid shift, so CPU read data never lands in csr_dat_o.
- CPU FSM:
  - IDLE -> ISSUE when granted. At end of N: sram_adr_o <= cpu_adr_i.
    - If cpu_we_i=1: sram_dat_o <= cpu_dat_i, sram_dat_oe_o <= 1, sram_we_n_o <= 0, sram_bw_n_o <= ~cpu_sel_i.
    - If cpu_we_i=0: sram_dat_oe_o <= 0, sram_we_n_o <= 1.
  - ISSUE (N+1): SRAM performs the access.
    - At end of N+1: if read, cpu_dat_o <= sram_dat_i. Then cpu_ack_o <= 1; we_n, bw_n and oe return to their idle values; go to ACK.
    - The display may own the N+1 slot concurrently; its address is registered normally.
  - ACK (N+2): cpu_ack_o=1 for exactly this cycle. At end of N+2: ack <= 0, go to IDLE.
  - The earliest next grant is N+3.
- Write with cpu_sel_i=2'b00: the SRAM cycle is still issued with bw_n=11, so no byte is written, and the access is acked normally.
- Data bus turnaround: sram_dat_oe_o is high only in the cycle after a CPU write grant. A display read in the following slot sees oe=0.
- CPU starvation: no timeout; the CPU waits through active display. Horizontal blanking (csr_stb_i=0) guarantees slots.
- Reset mid-access: the FSM returns to IDLE, no ack is produced and the pending request is dropped. The CPU must re-issue it.
- Address width: straight copy, no wrap logic. The address space is 128 K words.

Decomposition:
- Shared vga package:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, ACK=2'd2).
  - CSR_RD_LATENCY=2 constant, also used by the display-side pipeline alignment.
  - Idle SRAM control constants.
- No sub-module is required. The slot arbiter plus pipeline plus FSM fits in one module of roughly 150–200 lines.

Test Plan:
- Display burst: SRAM preloaded with mem[a]=a^16'hA5A5; csr_stb_i high at adr 0x100..0x10F for 16 cycles -> csr_dat_o = mem[0x100+k] at cycle k+2; sram_we_n_o stays 1 throughout.
- CPU write: csr_stb_i=0; write adr 0x00200, dat 0x1234, sel=2'b10 -> sram_bw_n_o=2'b01 and we_n=0 for 1 cycle; ack at grant+2; mem[0x200][15:8]=0x12 and the low byte is unchanged.
- CPU read blocked: cpu_stb_i read of 0x00300 while csr_stb_i is high for 40 cycles -> no SRAM CPU cycle and no ack during those cycles; the grant occurs on the first csr_stb_i=0 cycle; ack 2 cycles later with cpu_dat_o=mem[0x300].
- Interleave: CPU read granted at N, display strobe at N+1 (adr 0x400) -> cpu_dat_o=mem[cpu adr] at N+2 ack; csr_dat_o=mem[0x400] at N+3; csr_dat_o does not change at N+2.
- Reset mid-access: assert rst during ISSUE -> next cycle all outputs at reset values, cpu_ack_o is never asserted, and the FSM is IDLE.
- Turnaround: CPU write followed immediately by a display strobe -> sram_dat_oe_o=1 for the write cycle only and 0 for the display read; the display read returns the freshly written value.
